// File: rtl/vtx_trace_capture.sv
// Snoops the CPU<->COP handshake and COP memory port, emitting one record per retired instruction.
// vtx_valid pulses 2 cycles after respond; no backpressure. Optional timeout: VTX_CAPTURE_TIMEOUT_EN.
module vtx_trace_capture #(
    parameter int MEM_SLOTS      = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic           vtx_clk,
    input  logic           vtx_reset,
    input  logic           cop_cpu_req,
    input  logic           cop_cop_ack,
    input  logic           cop_cop_rsp,
    input  logic           cop_cpu_ack,
    input  logic [31:0]    cop_insn_enc,
    input  logic [31:0]    cop_rs1,
    input  logic [2:0]     cop_result,
    input  logic [31:0]    cop_wdata,
    input  logic [4:0]     cop_waddr,
    input  logic           cop_wen,
    input  logic [511:0]   cop_cprs,
    input  logic           mem_cen,
    input  logic           mem_wen,
    input  logic [3:0]     mem_ben,
    input  logic           mem_error,
    input  logic [31:0]    mem_addr,
    input  logic [31:0]    mem_wdata,
    input  logic [31:0]    mem_rdata,
    input  logic           mem_stall,
    output logic           vtx_valid,
    output logic [31:0]    vtx_instr_enc,
    output logic [31:0]    vtx_rs1,
    output logic [2:0]     vtx_result,
    output logic [31:0]    vtx_wdata,
    output logic [4:0]     vtx_waddr,
    output logic           vtx_wen,
    output logic [511:0]   vtx_cprs_pre,
    output logic [511:0]   vtx_cprs_post,
    output logic [3:0]     vtx_mem_cen,
    output logic [3:0]     vtx_mem_wen,
    output logic [3:0]     vtx_mem_error,
    output logic [15:0]    vtx_mem_ben,
    output logic [127:0]   vtx_mem_addr,
    output logic [127:0]   vtx_mem_wdata,
    output logic [127:0]   vtx_mem_rdata,
    output logic           vtx_mem_ovf,
    output logic           vtx_proto_err,
    output logic           vtx_timeout
);

    if (MEM_SLOTS != 4 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("vtx_trace_capture: MEM_SLOTS must be 4 and TIMEOUT_CYCLES at least 2");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        POST = 2'd2,
        EMIT = 2'd3
    } state_t;

    state_t         state;

    // Working record: filled while the instruction is in flight, published to
    // the vtx_* outputs in POST so the outputs stay stable across a back-to-back accept.
    logic [31:0]    enc_q;
    logic [31:0]    rs1_q;
    logic [2:0]     result_q;
    logic [31:0]    wdata_q;
    logic [4:0]     waddr_q;
    logic           wen_q;
    logic [511:0]   pre_q;
    logic [3:0]     cen_q;
    logic [3:0]     mwen_q;
    logic [3:0]     merr_q;
    logic [15:0]    ben_q;
    logic [127:0]   addr_q;
    logic [127:0]   mwdata_q;
    logic [127:0]   rdata_q;
    logic           ovf_q;
    logic [2:0]     count;

    logic           accept;
    logic           respond;
    logic           mem_done;
    logic           start;
    logic           proto_viol;
    logic [1:0]     slot;

    assign accept   = cop_cpu_req & cop_cop_ack;
    assign respond  = cop_cop_rsp & cop_cpu_ack;
    assign mem_done = mem_cen & ~mem_stall;
    assign slot     = count[1:0];
    assign start    = accept & ((state == IDLE) | (state == EMIT));

    assign proto_viol = (accept  & ((state == BUSY) | (state == POST)))
                      | (respond & ((state == IDLE) | (state == POST) | (state == EMIT)));

`ifdef VTX_CAPTURE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0]  tcnt;
    logic           timeout_hit;

    assign timeout_hit = (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge vtx_clk) begin
        if (vtx_reset) begin
            tcnt <= '0;
        end else if (start) begin
            tcnt <= '0;
        end else if (state == BUSY) begin
            tcnt <= tcnt + 1'b1;
        end
    end
`else
    logic           timeout_hit;

    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge vtx_clk) begin
        if (vtx_reset) begin
            state         <= IDLE;
            enc_q         <= '0;
            rs1_q         <= '0;
            result_q      <= '0;
            wdata_q       <= '0;
            waddr_q       <= '0;
            wen_q         <= 1'b0;
            pre_q         <= '0;
            cen_q         <= '0;
            mwen_q        <= '0;
            merr_q        <= '0;
            ben_q         <= '0;
            addr_q        <= '0;
            mwdata_q      <= '0;
            rdata_q       <= '0;
            ovf_q         <= 1'b0;
            count         <= '0;
            vtx_valid     <= 1'b0;
            vtx_instr_enc <= '0;
            vtx_rs1       <= '0;
            vtx_result    <= '0;
            vtx_wdata     <= '0;
            vtx_waddr     <= '0;
            vtx_wen       <= 1'b0;
            vtx_cprs_pre  <= '0;
            vtx_cprs_post <= '0;
            vtx_mem_cen   <= '0;
            vtx_mem_wen   <= '0;
            vtx_mem_error <= '0;
            vtx_mem_ben   <= '0;
            vtx_mem_addr  <= '0;
            vtx_mem_wdata <= '0;
            vtx_mem_rdata <= '0;
            vtx_mem_ovf   <= 1'b0;
            vtx_proto_err <= 1'b0;
            vtx_timeout   <= 1'b0;
        end else begin
            vtx_valid <= 1'b0;

            if (proto_viol) begin
                vtx_proto_err <= 1'b1;
            end

            if (start) begin
                enc_q    <= cop_insn_enc;
                rs1_q    <= cop_rs1;
                pre_q    <= cop_cprs;
                cen_q    <= '0;
                mwen_q   <= '0;
                merr_q   <= '0;
                ben_q    <= '0;
                addr_q   <= '0;
                mwdata_q <= '0;
                rdata_q  <= '0;
                ovf_q    <= 1'b0;
                count    <= '0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_done) begin
                        if (count == 3'(MEM_SLOTS)) begin
                            ovf_q <= 1'b1;
                        end else begin
                            cen_q[slot]              <= 1'b1;
                            mwen_q[slot]             <= mem_wen;
                            merr_q[slot]             <= mem_error;
                            ben_q[slot*4 +: 4]       <= mem_ben;
                            addr_q[slot*32 +: 32]    <= mem_addr;
                            mwdata_q[slot*32 +: 32]  <= mem_wdata;
                            rdata_q[slot*32 +: 32]   <= mem_rdata;
                            count                    <= count + 3'd1;
                        end
                    end
                    if (respond) begin
                        result_q <= cop_result;
                        wdata_q  <= cop_wdata;
                        waddr_q  <= cop_waddr;
                        wen_q    <= cop_wen;
                        state    <= POST;
                    end else if (timeout_hit) begin
                        vtx_timeout <= 1'b1;
                        state       <= IDLE;
                    end
                end
                POST: begin
                    // CPR writes from the instruction have landed by now.
                    vtx_cprs_post <= cop_cprs;
                    vtx_instr_enc <= enc_q;
                    vtx_rs1       <= rs1_q;
                    vtx_result    <= result_q;
                    vtx_wdata     <= wdata_q;
                    vtx_waddr     <= waddr_q;
                    vtx_wen       <= wen_q;
                    vtx_cprs_pre  <= pre_q;
                    vtx_mem_cen   <= cen_q;
                    vtx_mem_wen   <= mwen_q;
                    vtx_mem_error <= merr_q;
                    vtx_mem_ben   <= ben_q;
                    vtx_mem_addr  <= addr_q;
                    vtx_mem_wdata <= mwdata_q;
                    vtx_mem_rdata <= rdata_q;
                    vtx_mem_ovf   <= ovf_q;
                    vtx_valid     <= 1'b1;
                    state         <= EMIT;
                end
                EMIT: begin
                    state <= accept ? BUSY : IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
